fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream-facing to the decoder. Owns the program counter, drives the ROM address and active-low output enable, captures the combinational ROM word into an instruction register, and hands it to decode with a valid/ready handshake. Supports taken-branch redirection and, optionally, a halt-opcode stop.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 21 ++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The halt-opcode stop is enabled by defining FETCH_HALT_DETECT_EN.
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int              PC_W         = 8;
  localparam int              INSTR_W      = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = '1;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset, load (branch) beats increment beats hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int             PC_WIDTH = PC_W,
  parameter [PC_WIDTH-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ld,
  input  logic [PC_WIDTH-1:0] ld_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);
  // Increment wraps naturally at 2^PC_WIDTH.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)    pc <= RESET_PC;
    else if (ld)  pc <= ld_val;
    else if (inc) pc <= pc + 1'b1;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational ROM, hands words to decode.
// Define FETCH_HALT_DETECT_EN to stop fetching on an all-ones instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                PC_WIDTH    = PC_W,
  parameter int                INSTR_WIDTH = INSTR_W,
  parameter [PC_WIDTH-1:0]     RESET_PC    = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rstb,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   oeb,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   halted
);
  state_t state, state_nxt;
  logic   load, take, halt_hit, pc_ld, pc_inc;

  assign load = (state == ST_FETCH) && (!ir_valid || ir_ready);
  assign take = load && !branch_en;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = take && (instruction == {INSTR_WIDTH{1'b1}});
`else
  assign halt_hit = 1'b0;
`endif

  // Branches are honoured in IDLE and FETCH only; HALT ignores them.
  assign pc_ld  = branch_en && ((state == ST_IDLE) || (state == ST_FETCH));
  assign pc_inc = take && !halt_hit;

  fetch_pc_reg #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rstb   (rstb),
    .ld     (pc_ld),
    .ld_val (branch_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = halt_hit ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oeb    = !take;
    halted = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halted = (state == ST_HALT);
`endif
  end

  // A branch squashes the held word but leaves ir contents untouched.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if ((state == ST_FETCH) && branch_en) begin
      ir_valid <= 1'b0;
    end else if (take) begin
      ir       <= instruction;
      ir_valid <= 1'b1;
    end else if (ir_ready) begin
      ir_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table vectors, corner sequences, random vs model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [7:0]  pc;
  logic        oeb;
  logic [15:0] instruction;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halted;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign instruction = rom[pc];

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rstb(rstb), .pc(pc), .oeb(oeb), .instruction(instruction),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .branch_en(branch_en),
    .branch_target(branch_target), .halted(halted)
  );

  // Behavioural view: started = past the idle cycle, stopped = halt seen.
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_v, m_started, m_stopped;

  task automatic m_reset();
    m_pc = 8'h00; m_ir = 16'h0; m_v = 0; m_started = 0; m_stopped = 0;
  endtask

  function automatic bit m_oeb();
    if (!m_started || m_stopped) return 1'b1;
    return !((!m_v || ir_ready) && !branch_en);
  endfunction

  task automatic m_step();
    if (!m_started) begin
      if (branch_en) m_pc = branch_target;
      m_started = 1;
    end else if (m_stopped) begin
      if (ir_ready) m_v = 0;
    end else if (branch_en) begin
      m_pc = branch_target; m_v = 0;
    end else if (!m_v || ir_ready) begin
      m_ir = rom[m_pc]; m_v = 1;
      if (HD && m_ir == 16'hFFFF) m_stopped = 1;
      else m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_pc", pc, m_pc);
    chk("m_ir_valid", ir_valid, m_v);
    if (m_v) chk("m_ir", ir, m_ir);
    chk("m_oeb", oeb, m_oeb());
    chk("m_halted", halted, m_stopped);
  endtask

  // Drive at posedge+1, check at negedge; caller may add checks, then tick().
  task automatic drive(input bit rdy, input bit br, input logic [7:0] tgt);
    ir_ready = rdy; branch_en = br; branch_target = tgt;
    @(negedge clk);
    chk_model();
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    ir_ready = 0; branch_en = 0; branch_target = 0;
    rstb = 0; m_reset();
    repeat (2) @(posedge clk);
    #1 rstb = 1;
  endtask

  typedef struct {
    bit rdy; bit br; logic [7:0] tgt;
    logic [7:0] e_pc; bit e_v; logic [15:0] e_ir; bit e_oeb;
  } vec_t;
  vec_t vt[$];

  function automatic logic [15:0] rw(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, ~a};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rw(i);

    do_reset();
    @(negedge clk);
    chk("reset_pc", pc, 8'h00);
    chk("reset_valid", ir_valid, 1'b0);
    chk("reset_ir", ir, 16'h0);
    chk("reset_oeb", oeb, 1'b1);
    chk("reset_halted", halted, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // Cycle 0 is IDLE; first ir_valid shows in cycle 2.
    vt.push_back('{1, 0, 8'h00, 8'h00, 0, 16'h0,   1});
    vt.push_back('{1, 0, 8'h00, 8'h00, 0, 16'h0,   0});
    vt.push_back('{1, 0, 8'h00, 8'h01, 1, rw(0),   0});
    vt.push_back('{0, 0, 8'h00, 8'h02, 1, rw(1),   1});
    vt.push_back('{0, 0, 8'h00, 8'h02, 1, rw(1),   1});
    vt.push_back('{0, 0, 8'h00, 8'h02, 1, rw(1),   1});
    vt.push_back('{1, 0, 8'h00, 8'h02, 1, rw(1),   0});
    vt.push_back('{1, 1, 8'h40, 8'h03, 1, rw(2),   1});
    vt.push_back('{1, 0, 8'h00, 8'h40, 0, rw(2),   0});
    vt.push_back('{1, 0, 8'h00, 8'h41, 1, rw(8'h40), 0});
    vt.push_back('{1, 0, 8'h00, 8'h42, 1, rw(8'h41), 0});
    foreach (vt[i]) begin
      drive(vt[i].rdy, vt[i].br, vt[i].tgt);
      chk($sformatf("tv%0d_pc", i), pc, vt[i].e_pc);
      chk($sformatf("tv%0d_valid", i), ir_valid, vt[i].e_v);
      chk($sformatf("tv%0d_ir", i), ir, vt[i].e_ir);
      chk($sformatf("tv%0d_oeb", i), oeb, vt[i].e_oeb);
      tick();
    end

    // PC wrap at 8'hFF.
    drive(1, 1, 8'hFF); tick();
    drive(1, 0, 8'h00); chk("wrap_pc_ff", pc, 8'hFF); chk("wrap_bubble", ir_valid, 1'b0); tick();
    drive(1, 0, 8'h00); chk("wrap_pc_00", pc, 8'h00); chk("wrap_ir_ff", ir, rw(255)); tick();
    drive(1, 0, 8'h00); chk("wrap_pc_01", pc, 8'h01); chk("wrap_ir_00", ir, rw(0)); tick();

    // Asynchronous reset mid-stream.
    drive(0, 0, 8'h00);
    #1 rstb = 0; m_reset();
    #1;
    chk("arst_valid", ir_valid, 1'b0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_oeb", oeb, 1'b1);
    chk("arst_halted", halted, 1'b0);
    @(posedge clk); #1 rstb = 1;

    // Halt opcode at ROM[2].
    rom[2] = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin drive(1, 0, 8'h00); tick(); end
    drive(1, 1, 8'h80);
    chk("halt_ir", ir, 16'hFFFF);
    chk("halt_valid", ir_valid, 1'b1);
    if (HD) begin
      chk("halt_pc", pc, 8'h02); chk("halt_flag", halted, 1'b1); chk("halt_oeb", oeb, 1'b1);
    end else begin
      chk("nohalt_pc", pc, 8'h03); chk("nohalt_flag", halted, 1'b0);
    end
    tick();
    drive(1, 0, 8'h00);
    if (HD) begin
      chk("halt_br_ignored", pc, 8'h02); chk("halt_valid_clr", ir_valid, 1'b0);
    end else chk("nohalt_br_taken", pc, 8'h80);
    tick();
    rom[2] = rw(2);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
